// File: rtl/data_mem_bridge.sv
// data_mem_bridge
//   Bridges the core's MEM-stage data port onto a ready/valid, variable
//   latency data bus. One load/store is latched from the core, issued on the
//   bus, and its response is presented back with mem_valid so the hazard unit
//   can release stall_mem. A watchdog aborts accesses that hang in REQ/WAIT.
//
// Ports
//   clk, rst        : rising-edge clock, asynchronous active-high reset
//   core_req        : valid load/store present in MEM stage
//   core_ack        : MEM stage advancing this cycle (~stall_mem)
//   core_we         : 1 = store, 0 = load
//   core_adr        : byte address
//   core_wdata      : lane-aligned store data
//   core_wmask      : byte-lane write mask
//   core_rdata      : last captured load word (0 after a timeout)
//   mem_valid       : data port ready / access complete
//   bus_req_valid   : request valid            bus_req_ready : request accepted
//   bus_we          : request is a write       bus_adr       : word-aligned address
//   bus_wdata       : write data               bus_wstrb     : byte strobes
//   bus_rsp_valid   : response valid           bus_rsp_data  : read data
//   bus_rsp_err     : response error
//   bus_error       : sticky error flag (bus error or watchdog timeout)
module data_mem_bridge #(
  parameter int unsigned TIMEOUT = 255,
  parameter int unsigned CNT_W   = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        core_req,
  input  logic        core_ack,
  input  logic        core_we,
  input  logic [31:0] core_adr,
  input  logic [31:0] core_wdata,
  input  logic [3:0]  core_wmask,
  output logic [31:0] core_rdata,
  output logic        mem_valid,
  output logic        bus_req_valid,
  input  logic        bus_req_ready,
  output logic        bus_we,
  output logic [31:0] bus_adr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_wstrb,
  input  logic        bus_rsp_valid,
  input  logic [31:0] bus_rsp_data,
  input  logic        bus_rsp_err,
  output logic        bus_error
);

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_wd;
  logic [CNT_W-1:0] w_wd_inc;
  logic             r_we;
  logic [31:2]      r_adr;
  logic [31:0]      r_wdata;
  logic [3:0]       r_wmask;
  logic [31:0]      r_rdata;
  logic             r_err;

  logic w_active;
  logic w_accept;
  logic w_capture;
  logic w_timeout;
  logic w_unused_adr_lsb;

  // Byte offset is dropped: the bus is word addressed.
  assign w_unused_adr_lsb = ^core_adr[1:0];

  assign w_active = (r_state == S_REQ) || (r_state == S_WAIT);
  assign w_accept = (r_state == S_REQ) && bus_req_ready;
  // A response is only meaningful once the request has been (or is being) accepted.
  assign w_capture = bus_rsp_valid && ((r_state == S_WAIT) || w_accept);
  // w_wd_inc is the number of REQ+WAIT cycles including the current one, so
  // the abort happens in the TIMEOUT-th cycle; a same-cycle response wins.
  assign w_wd_inc  = r_wd + CNT_W'(1);
  assign w_timeout = w_active && (w_wd_inc == TIMEOUT_C) && !w_capture;

  always_comb begin
    w_state_next  = r_state;
    mem_valid     = 1'b0;
    bus_req_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        mem_valid = ~core_req;
        if (core_req) w_state_next = S_REQ;
      end
      S_REQ: begin
        bus_req_valid = 1'b1;
        if (w_capture || w_timeout) w_state_next = S_DONE;
        else if (w_accept)          w_state_next = S_WAIT;
      end
      S_WAIT: begin
        if (w_capture || w_timeout) w_state_next = S_DONE;
      end
      S_DONE: begin
        mem_valid = 1'b1;
        if (core_ack) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_wd    <= '0;
      r_we    <= 1'b0;
      r_adr   <= '0;
      r_wdata <= '0;
      r_wmask <= '0;
      r_rdata <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;

      if ((r_state == S_IDLE) && core_req) begin
        r_wd    <= '0;
        r_we    <= core_we;
        r_adr   <= core_adr[31:2];
        r_wdata <= core_wdata;
        r_wmask <= core_wmask;
      end else if (w_active) begin
        r_wd <= w_wd_inc;
      end

      if (w_capture && !r_we) r_rdata <= bus_rsp_data;
      else if (w_timeout)     r_rdata <= '0;

      if ((w_capture && bus_rsp_err) || w_timeout) r_err <= 1'b1;
    end
  end

  assign bus_we     = r_we;
  assign bus_adr    = {r_adr, 2'b00};
  assign bus_wdata  = r_wdata;
  assign bus_wstrb  = r_wmask;
  assign core_rdata = r_rdata;
  assign bus_error  = r_err;

endmodule

// File: doc/data_mem_bridge.md
Name: data_mem_bridge

Overview:
Bridges the core's MEM-stage data port to a ready/valid, variable-latency data bus (SRAM controller or interconnect).
- Latches one load/store request from the core and issues it on the bus.
- Waits for the response, then presents read data and raises mem_valid so the hazard unit can release stall_mem.
- Sits directly downstream of the core's memory-stage outputs.
- Includes a watchdog that terminates hung accesses.

Parameters:
TIMEOUT  255  max cycles spent in REQ+WAIT before the access is aborted (1..65535)
CNT_W  16  watchdog counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
core_req  input  1  valid load/store present in MEM stage
core_ack  input  1  core pipeline advancing out of MEM this cycle (~stall_mem)
core_we  input  1  1 = store, 0 = load
core_adr  input  32  byte address from MEM stage
core_wdata  input  32  store data, already lane-aligned
core_wmask  input  4  byte-lane write mask
core_rdata  output  32  word read from bus
mem_valid  output  1  data port ready / access complete
bus_req_valid  output  1  request valid
bus_req_ready  input  1  bus accepts request
bus_we  output  1  request is a write
bus_adr  output  32  word-aligned address
bus_wdata  output  32  write data
bus_wstrb  output  4  byte strobes
bus_rsp_valid  input  1  response valid
bus_rsp_data  input  32  read data
bus_rsp_err  input  1  bus error on response
bus_error  output  1  sticky error flag (bus error or timeout)

Behaviour:
- Reset (asynchronous) forces the following, regardless of clk:
  - state = IDLE, watchdog = 0.
  - All latched request fields = 0; core_rdata = 0; bus_error = 0.
  - bus_req_valid = 0.
- FSM states are IDLE, REQ, WAIT, DONE.
- IDLE:
  - mem_valid = ~core_req (combinational).
  - If core_req = 1: latch we, adr, wdata and wmask, go to REQ.
  - If core_req = 0, stay in IDLE.
- REQ:
  - bus_req_valid = 1; bus_adr = {latched_adr[31:2], 2'b00}; bus_we, bus_wdata and bus_wstrb come from the latches.
  - Latched fields are stable until accepted.
  - When bus_req_valid & bus_req_ready: go to WAIT.
  - If bus_rsp_valid is also high in that same cycle, capture the response and go directly to DONE.
  - mem_valid = 0.
- WAIT:
  - bus_req_valid = 0, mem_valid = 0.
  - On bus_rsp_valid, go to DONE and capture the response:
    - load: core_rdata = bus_rsp_data;
    - store: core_rdata is unchanged;
    - bus_rsp_err = 1 sets bus_error.
  - bus_rsp_valid in IDLE or DONE is ignored.
- DONE:
  - mem_valid = 1; core_rdata is held.
  - core_ack = 1: go to IDLE.
  - core_ack = 0: stay in DONE, so a stalled MEM stage is not re-issued.
- Watchdog:
  - Clears on entry to REQ and increments each cycle in REQ or WAIT.
  - When it equals TIMEOUT and no response is captured that cycle, go to DONE with core_rdata = 0 and set bus_error.
  - An outstanding response arriving later is dropped.
- Latency:
  - Minimum 2 cycles from core_req to mem_valid: IDLE→REQ→DONE with same-cycle ready+response.
  - Typical access is 1 + request wait + response latency + 1.
- bus_error is sticky; it clears only on rst.
- core_rdata updates only on a load response capture or a timeout; it is otherwise stable.
- Asserting rst mid-access abandons the access. A bus response returning after reset is ignored in IDLE.

Test Plan:
- Load, zero-wait bus: core_req = 1, we = 0, adr = 0x0000_1006; ready = 1 and rsp_valid = 1 with data 0xDEAD_BEEF on the REQ cycle → bus_adr = 0x0000_1004, mem_valid = 1 and core_rdata = 0xDEAD_BEEF in cycle 2.
- Store, back-pressured: we = 1, wdata = 0x0000_00AB, wmask = 4'b0001; ready held low 3 cycles, response 2 cycles later → bus fields stable through the stall, mem_valid = 0 until DONE, core_rdata unchanged.
- Stalled pipeline: after DONE hold core_ack = 0 for 4 cycles with core_req = 1 → mem_valid stays 1, no second bus_req_valid pulse; core_ack = 1 → IDLE.
- Timeout: TIMEOUT = 8, ready = 1, never respond → DONE after 8 REQ+WAIT cycles, core_rdata = 0, bus_error = 1; a late response 5 cycles later is ignored.
- Bus error: response with bus_rsp_err = 1 → bus_error = 1, access completes normally; bus_error stays 1 over the next 10 accesses.
- Reset mid-access: assert rst in WAIT → bus_req_valid = 0, state IDLE immediately, mem_valid = 1 with core_req = 0; the stale response after reset is ignored.
